// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide
// with architecturally visible HI/LO result registers.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t state_n;

    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod;

    logic             take;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign take  = (state == IDLE) && start && !flush;
    assign sgn   = ~op[0];
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quot_step;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                   + (prod[0] ? {1'b0, mag_a} : '0);
    assign prod_step = {add_sum, prod[WIDTH-1:1]};

    // Bit WIDTH of diff is the borrow: set when shifted < divisor.
    assign shifted   = {rem, quot[WIDTH-1]};
    assign diff      = shifted - {1'b0, mag_b};
    assign rem_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_step = {quot[WIDTH-2:0], ~diff[WIDTH]};

    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -quot : quot;
    assign rem_fix  = neg_r ? -rem : rem;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (take && !op[2]) begin
                    state_n = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (cnt == LAST) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            quot     <= '0;
            rem      <= '0;
            prod     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        unique case (1'b1)
                            !op[2]: begin
                                cnt      <= '0;
                                is_div   <= op[1];
                                neg_q    <= a_neg ^ b_neg;
                                neg_r    <= a_neg;
                                div_zero <= (b == '0);
                                a_raw    <= a;
                                mag_a    <= a_mag;
                                mag_b    <= b_mag;
                                quot     <= a_mag;
                                rem      <= '0;
                                prod     <= {{WIDTH{1'b0}}, b_mag};
                            end
                            (op == 3'd4): hi <= a;
                            (op == 3'd5): lo <= a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    cnt  <= cnt + 1'b1;
                    prod <= prod_step;
                    rem  <= rem_step;
                    quot <= quot_step;
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors plus an arithmetic reference
// model compared against the unit on every cycle.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void ref_result(input logic [2:0] o,
                                       input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       output logic [W-1:0] rh,
                                       output logic [W-1:0] rl);
        longint sx;
        longint sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin
                r = sx * sy;
                rh = r[63:32];
                rl = r[31:0];
            end
            3'd1: begin
                r = ux * uy;
                rh = r[63:32];
                rl = r[31:0];
            end
            3'd2: begin
                if (y == 0) begin
                    rh = x;
                    rl = '1;
                end else begin
                    r = sx / sy;
                    rl = r[31:0];
                    r = sx % sy;
                    rh = r[31:0];
                end
            end
            default: begin
                if (y == 0) begin
                    rh = x;
                    rl = '1;
                end else begin
                    r = ux / uy;
                    rl = r[31:0];
                    r = ux % uy;
                    rh = r[31:0];
                end
            end
        endcase
    endfunction

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] p_hi;
    logic [W-1:0] p_lo;
    logic         m_busy;
    logic         m_done;
    int           remain;
    bit           m_valid = 1'b0;

    // Model: a result lands WIDTH+1 edges after acceptance.
    task automatic model_step();
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            remain = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (remain > 0) begin
                if (flush) begin
                    remain = 0;
                end else begin
                    remain--;
                    if (remain == 0) begin
                        m_hi = p_hi;
                        m_lo = p_lo;
                        m_done = 1'b1;
                    end
                end
            end else if (start && !flush) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        ref_result(op, a, b, p_hi, p_lo);
                        remain = W + 1;
                    end
                    3'd4: m_hi = a;
                    3'd5: m_lo = a;
                    default: ;
                endcase
            end
            m_busy = (remain > 0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            chk("cyc_done", {63'd0, done}, {63'd0, m_done});
            chk("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            chk("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        issue(o, x, y);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk({name, "_latency"}, 64'(n), 64'd33);
        chk({name, "_done"}, {63'd0, done}, 64'd1);
        chk({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({name, "_lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
        step();
        chk("mult_done_pulse", {63'd0, done}, 64'd0);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
        run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000);
        run_op("div_rem", 3'd2, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_zero", 3'd3, 32'd7, 32'd0,
               32'h0000_0007, 32'hFFFF_FFFF);

        issue(3'd4, 32'h1234, 32'd0);
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        chk("mthi_busy", {63'd0, busy}, 64'd0);

        issue(3'd0, 32'd3, 32'd4);
        step();
        step();
        issue(3'd5, 32'hDEAD, 32'd0);
        chk("mtlo_ignored", {32'd0, lo}, 64'hFFFF_FFFF);
        repeat (6) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_done", {63'd0, done}, 64'd0);
        chk("flush_hi", {32'd0, hi}, 64'h1234);
        chk("flush_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        repeat (40) step();

        op = 3'd4;
        a = 32'h5555;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_hi", {32'd0, hi}, 64'h1234);

        issue(3'd0, 32'd3, 32'd4);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        repeat (5) step();

        run_op("mult_small", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12);
        run_op("divu_b2b", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
